// File: rtl/ahb3lite_master_arbiter_if.sv
// Bus bundle between several AHB-Lite masters, the arbiter, and the single shared slave port.
// Modport "master" is the arbiter's view; modport "slave" is the view of the masters and slave around it.
interface ahb3lite_master_arbiter_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int MASTERS    = 2
);
    logic [MASTERS*HADDR_SIZE-1:0] m_haddr_i;
    logic [MASTERS*2-1:0]          m_htrans_i;
    logic [MASTERS-1:0]            m_hwrite_i;
    logic [MASTERS*3-1:0]          m_hsize_i;
    logic [MASTERS*3-1:0]          m_hburst_i;
    logic [MASTERS*4-1:0]          m_hprot_i;
    logic [MASTERS*HDATA_SIZE-1:0] m_hwdata_i;
    logic [HDATA_SIZE-1:0]         m_hrdata_o;
    logic [MASTERS-1:0]            m_hready_o;
    logic [MASTERS-1:0]            m_hresp_o;

    logic                          s_hsel_o;
    logic [HADDR_SIZE-1:0]         s_haddr_o;
    logic [1:0]                    s_htrans_o;
    logic                          s_hwrite_o;
    logic [2:0]                    s_hsize_o;
    logic [2:0]                    s_hburst_o;
    logic [3:0]                    s_hprot_o;
    logic [HDATA_SIZE-1:0]         s_hwdata_o;
    logic                          s_hready_o;
    logic [HDATA_SIZE-1:0]         s_hrdata_i;
    logic                          s_hreadyout_i;
    logic                          s_hresp_i;

    logic [MASTERS-1:0]            grant_o;

    modport master (
        input  m_haddr_i, m_htrans_i, m_hwrite_i, m_hsize_i, m_hburst_i, m_hprot_i, m_hwdata_i,
        input  s_hrdata_i, s_hreadyout_i, s_hresp_i,
        output m_hrdata_o, m_hready_o, m_hresp_o,
        output s_hsel_o, s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hburst_o, s_hprot_o,
        output s_hwdata_o, s_hready_o, grant_o
    );

    modport slave (
        output m_haddr_i, m_htrans_i, m_hwrite_i, m_hsize_i, m_hburst_i, m_hprot_i, m_hwdata_i,
        output s_hrdata_i, s_hreadyout_i, s_hresp_i,
        input  m_hrdata_o, m_hready_o, m_hresp_o,
        input  s_hsel_o, s_haddr_o, s_htrans_o, s_hwrite_o, s_hsize_o, s_hburst_o, s_hprot_o,
        input  s_hwdata_o, s_hready_o, grant_o
    );
endinterface

// File: rtl/ahb3lite_master_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite slave between MASTERS masters, with bus parking.
// The grant moves only on an IDLE owner address phase, so transfers are never split or replayed.
module ahb3lite_master_arbiter #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int MASTERS    = 2
) (
    input logic                       hclk_i,
    input logic                       hreset_n_i,
    ahb3lite_master_arbiter_if.master bus
);
    localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    logic [MASTERS-1:0] grant_q;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   dp_owner;
    logic               dp_valid;
    logic [MASTERS-1:0] req;
    logic               found;
    int                 owner_idx;
    int                 next_idx;

    always_comb begin
        owner_idx = 0;
        for (int i = 0; i < MASTERS; i++) begin
            req[i] = bus.m_htrans_i[2*i+1];
            if (grant_q[i]) owner_idx = i;
        end
    end

    always_comb begin
        bus.s_haddr_o  = '0;
        bus.s_htrans_o = 2'b00;
        bus.s_hwrite_o = 1'b0;
        bus.s_hsize_o  = 3'b000;
        bus.s_hburst_o = 3'b000;
        bus.s_hprot_o  = 4'b0000;
        bus.s_hwdata_o = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (i == owner_idx) begin
                bus.s_haddr_o  = bus.m_haddr_i[i*HADDR_SIZE +: HADDR_SIZE];
                bus.s_htrans_o = bus.m_htrans_i[2*i +: 2];
                bus.s_hwrite_o = bus.m_hwrite_i[i];
                bus.s_hsize_o  = bus.m_hsize_i[3*i +: 3];
                bus.s_hburst_o = bus.m_hburst_i[3*i +: 3];
                bus.s_hprot_o  = bus.m_hprot_i[4*i +: 4];
            end
            if (i == int'(dp_owner)) bus.s_hwdata_o = bus.m_hwdata_i[i*HDATA_SIZE +: HDATA_SIZE];
        end
    end

    // Scan starts after the last granted master; the current owner comes last, so it parks by default.
    always_comb begin
        next_idx = owner_idx;
        found    = 1'b0;
        for (int k = 1; k <= MASTERS; k++) begin
            for (int i = 0; i < MASTERS; i++) begin
                if (!found && req[i] && (i == (int'(last_q) + k) % MASTERS)) begin
                    next_idx = i;
                    found    = 1'b1;
                end
            end
        end
    end

    // A requesting non-owner is stalled so it keeps presenting its address until granted.
    always_comb begin
        bus.m_hready_o = '1;
        bus.m_hresp_o  = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (i == owner_idx)
                bus.m_hready_o[i] = bus.s_hreadyout_i;
            else if (req[i])
                bus.m_hready_o[i] = 1'b0;
            else if (dp_valid && (i == int'(dp_owner)))
                bus.m_hready_o[i] = bus.s_hreadyout_i;
            if (dp_valid && (i == int'(dp_owner)))
                bus.m_hresp_o[i] = bus.s_hresp_i;
        end
    end

    assign bus.s_hsel_o   = bus.s_htrans_o[1];
    assign bus.s_hready_o = bus.s_hreadyout_i;
    assign bus.m_hrdata_o = bus.s_hrdata_i;
    assign bus.grant_o    = grant_q;

    always_ff @(posedge hclk_i or negedge hreset_n_i) begin
        if (!hreset_n_i) begin
            grant_q  <= MASTERS'(1);
            last_q   <= '0;
            dp_valid <= 1'b0;
            dp_owner <= '0;
        end else if (bus.s_hreadyout_i) begin
            dp_valid <= bus.s_htrans_o[1];
            dp_owner <= IDX_W'(owner_idx);
            if (bus.s_htrans_o == 2'b00) begin
                grant_q <= MASTERS'(1) << next_idx;
                last_q  <= IDX_W'(next_idx);
            end
        end
    end
endmodule
